post_decryption: RTL and testbench

Decapsulation-side key-derivation controller for the Kyber KEM; counterpart of the encapsulation pre-encryption stage. Given the decrypted message m', the stored hash h = H(ek) and the implicit-rejection secret z, it requests (K', r') = G(m' || h) and hands r' to the re-encryption engine. It then compares the re-encrypted ciphertext against the received ciphertext word by word and releases either K' or the rejection key J(z || c). It sits between the decryption core and the top-level decaps output, and drives external SHA3-512 (G) and SHAKE256 (J) units through request/valid handshakes.

---
 rtl/kyber_pkg.sv | 25 ++
 rtl/ct_compare.sv | 53 +++++
 rtl/post_decryption.sv | 175 +++++++++++++++++
 tb/tb_post_decryption.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the post-decryption controller state type.
package kyber_pkg;

  localparam int KYBER_N        = 256;
  localparam int KYBER_CT_BYTES = 1088;

  typedef enum logic [2:0] {
    IDLE,
    G_REQ,
    COIN,
    COMPARE,
    J_REQ,
    DONE
  } post_dec_state_t;

  // Branch-free key selection: a full-width mask built from sel picks a or b.
  function automatic logic [KYBER_N-1:0] mask_select(input logic               sel,
                                                     input logic [KYBER_N-1:0] a,
                                                     input logic [KYBER_N-1:0] b);
    logic [KYBER_N-1:0] mask;
    mask = {KYBER_N{sel}};
    return (a & mask) | (b & ~mask);
  endfunction

endpackage

// File: rtl/ct_compare.sv
// Ciphertext compare engine: counts beats, accumulates word mismatches and
// flags a stream whose length is not exactly CT_WORDS.
module ct_compare #(
  parameter int WORD_W   = 64,
  parameter int CT_WORDS = 136
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              beat,
  input  logic              last,
  input  logic [WORD_W-1:0] word_a,
  input  logic [WORD_W-1:0] word_b,
  output logic              done,
  output logic              mismatch
);

  localparam int CNT_W = $clog2(CT_WORDS + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             last_idx;
  logic             beat_bad;

  // Judge the current beat and fold it into the running mismatch flag.
  always_comb begin
    last_idx = (cnt_q == CNT_W'(CT_WORDS - 1));
    beat_bad = (word_a != word_b) | (last != last_idx);
    done     = beat & (last | last_idx);
    mismatch = flag_q | (beat & beat_bad);
    cnt_d    = cnt_q;
    flag_d   = flag_q;
    if (clear) begin
      cnt_d  = '0;
      flag_d = 1'b0;
    end else if (beat) begin
      cnt_d  = cnt_q + CNT_W'(1);
      flag_d = flag_q | beat_bad;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

endmodule

// File: rtl/post_decryption.sv
// Kyber decapsulation key-derivation controller: G request, coin hand-off,
// ciphertext compare and implicit-rejection key selection.
// Optional build macro POST_DEC_CONST_TIME_EN: always request J and select
// the key with a mask so latency is independent of the compare result.
module post_decryption
  import kyber_pkg::*;
#(
  parameter int WORD_W   = 64,
  parameter int CT_WORDS = 136
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KYBER_N-1:0]   m_prime,
  input  logic [KYBER_N-1:0]   h_ek,
  input  logic [KYBER_N-1:0]   z,
  output logic                 g_req,
  output logic [2*KYBER_N-1:0] g_in,
  input  logic                 g_valid,
  input  logic [2*KYBER_N-1:0] g_out,
  output logic [KYBER_N-1:0]   coin,
  output logic                 coin_valid,
  input  logic                 ct_valid,
  input  logic                 ct_last,
  input  logic [WORD_W-1:0]    ct_word,
  input  logic [WORD_W-1:0]    ct_re_word,
  output logic                 ct_ready,
  output logic                 j_req,
  output logic [KYBER_N-1:0]   j_z,
  input  logic                 j_valid,
  input  logic [KYBER_N-1:0]   j_out,
  output logic [KYBER_N-1:0]   shared_key,
  output logic                 reject,
  output logic                 valid,
  output logic                 busy
);

  post_dec_state_t state_q, state_d;

  logic [KYBER_N-1:0] m_q, m_d;
  logic [KYBER_N-1:0] h_q, h_d;
  logic [KYBER_N-1:0] z_q, z_d;
  logic [KYBER_N-1:0] k_q, k_d;
  logic [KYBER_N-1:0] r_q, r_d;
  logic [KYBER_N-1:0] key_q, key_d;
  logic               reject_q, reject_d;

  logic cmp_clear;
  logic cmp_done;
  logic cmp_mismatch;

  ct_compare #(
    .WORD_W  (WORD_W),
    .CT_WORDS(CT_WORDS)
  ) u_ct_compare (
    .clk     (clk),
    .rst     (rst),
    .clear   (cmp_clear),
    .beat    (ct_valid & ct_ready),
    .last    (ct_last),
    .word_a  (ct_word),
    .word_b  (ct_re_word),
    .done    (cmp_done),
    .mismatch(cmp_mismatch)
  );

  assign g_in       = {h_q, m_q};
  assign coin       = r_q;
  assign j_z        = z_q;
  assign shared_key = key_q;
  assign reject     = reject_q;
  assign busy       = (state_q != IDLE);

  // Next-state, secret latching and handshake outputs.
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    h_d        = h_q;
    z_d        = z_q;
    k_d        = k_q;
    r_d        = r_q;
    key_d      = key_q;
    reject_d   = reject_q;
    cmp_clear  = 1'b0;
    g_req      = 1'b0;
    coin_valid = 1'b0;
    ct_ready   = 1'b0;
    j_req      = 1'b0;
    valid      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d       = m_prime;
          h_d       = h_ek;
          z_d       = z;
          cmp_clear = 1'b1;
          state_d   = G_REQ;
        end
      end
      G_REQ: begin
        g_req = 1'b1;
        if (g_valid) begin
          k_d     = g_out[KYBER_N-1:0];
          r_d     = g_out[2*KYBER_N-1:KYBER_N];
          state_d = COIN;
        end
      end
      COIN: begin
        coin_valid = 1'b1;
        state_d    = COMPARE;
      end
      COMPARE: begin
        ct_ready = 1'b1;
        if (cmp_done) begin
`ifdef POST_DEC_CONST_TIME_EN
          state_d = J_REQ;
`else
          if (cmp_mismatch) begin
            state_d = J_REQ;
          end else begin
            key_d    = k_q;
            reject_d = 1'b0;
            state_d  = DONE;
          end
`endif
        end
      end
      J_REQ: begin
        j_req = 1'b1;
        if (j_valid) begin
`ifdef POST_DEC_CONST_TIME_EN
          key_d = mask_select(cmp_mismatch, j_out, k_q);
`else
          key_d = cmp_mismatch ? j_out : k_q;
`endif
          reject_d = cmp_mismatch;
          state_d  = DONE;
        end
      end
      DONE: begin
        valid   = 1'b1;
        m_d     = '0;
        z_d     = '0;
        k_d     = '0;
        r_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears every secret and output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      m_q      <= '0;
      h_q      <= '0;
      z_q      <= '0;
      k_q      <= '0;
      r_q      <= '0;
      key_q    <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      h_q      <= h_d;
      z_q      <= z_d;
      k_q      <= k_d;
      r_q      <= r_d;
      key_q    <= key_d;
      reject_q <= reject_d;
    end
  end

endmodule

// File: tb/tb_post_decryption.sv
// Randomized bench for post_decryption with a schedule-level reference model.
module tb_post_decryption;

  localparam int WORD_W   = 64;
  localparam int CT_WORDS = 136;
  localparam int MAXC     = 1500;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [255:0]       m_prime, h_ek, z;
  logic               g_req;
  logic [511:0]       g_in;
  logic               g_valid;
  logic [511:0]       g_out;
  logic [255:0]       coin;
  logic               coin_valid;
  logic               ct_valid, ct_last;
  logic [WORD_W-1:0]  ct_word, ct_re_word;
  logic               ct_ready;
  logic               j_req;
  logic [255:0]       j_z;
  logic               j_valid;
  logic [255:0]       j_out;
  logic [255:0]       shared_key;
  logic               reject;
  logic               valid;
  logic               busy;

  int checks = 0;
  int errors = 0;

  logic [WORD_W-1:0] ct_data [CT_WORDS];

  post_decryption #(.WORD_W(WORD_W), .CT_WORDS(CT_WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .m_prime(m_prime), .h_ek(h_ek), .z(z),
    .g_req(g_req), .g_in(g_in), .g_valid(g_valid), .g_out(g_out),
    .coin(coin), .coin_valid(coin_valid),
    .ct_valid(ct_valid), .ct_last(ct_last), .ct_word(ct_word), .ct_re_word(ct_re_word),
    .ct_ready(ct_ready), .j_req(j_req), .j_z(j_z), .j_valid(j_valid), .j_out(j_out),
    .shared_key(shared_key), .reject(reject), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_inputs();
    start = 0; g_valid = 0; j_valid = 0; ct_valid = 0; ct_last = 0;
    ct_word = '0; ct_re_word = '0;
  endtask

  // One decapsulation. Relative cycle 0 is the cycle start is presented.
  // last_at > CT_WORDS-1 means ct_last is never sent.
  task automatic run_txn(input string name, input bit fixed, input int g_rel, input int pat,
                         input int bad_idx, input int bad_bit, input int last_at,
                         input int j_lat, input bit abort);
    logic [255:0] mm, hh, zz, kk, rr, jj, key_exp;
    bit vpat [MAXC];
    int n, lc, cnt, jv_rel, vexp, idx, stop;
    bit mis, use_j;
    int valid_cnt, valid_first, coin_first, ready_first, jreq_first;
    logic [255:0] coin_seen, key_seen;
    logic rej_seen, jz_ok;

    mm = rand256(); hh = rand256(); zz = rand256();
    kk = rand256(); rr = rand256(); jj = rand256();
    if (fixed) begin
      rr = {64{4'h5}};
      kk = {64{4'hA}};
      jj = {16{16'h1234}};
    end
    for (int i = 0; i < CT_WORDS; i++) ct_data[i] = {$urandom, $urandom};
    for (int r = 0; r < MAXC; r++) begin
      case (pat)
        0:       vpat[r] = 1'b1;
        1:       vpat[r] = (r % 2 == 0);
        default: vpat[r] = ($urandom_range(0, 3) != 0);
      endcase
    end

    // Reference model: beats needed, last beat cycle, outcome and valid cycle.
    n = ((last_at < CT_WORDS - 1) ? last_at : CT_WORDS - 1) + 1;
    cnt = 0;
    lc = -1;
    for (int r = g_rel + 2; r < MAXC && lc < 0; r++) begin
      if (vpat[r]) begin
        cnt++;
        if (cnt == n) lc = r;
      end
    end
    mis = (bad_idx >= 0 && bad_idx < n) || (last_at != CT_WORDS - 1);
`ifdef POST_DEC_CONST_TIME_EN
    use_j = 1'b1;
`else
    use_j = mis;
`endif
    jv_rel  = lc + 1 + j_lat;
    vexp    = use_j ? jv_rel + 1 : lc + 1;
    key_exp = mis ? jj : kk;
    stop    = abort ? g_rel + 10 : vexp + 3;

    valid_cnt = 0; valid_first = -1; coin_first = -1; ready_first = -1; jreq_first = -1;
    coin_seen = '0; key_seen = '0; rej_seen = 1'b0; jz_ok = 1'b1;
    cnt = 0;

    @(negedge clk);
    for (int rel = 0; rel <= stop; rel++) begin
      // Observe the cycle.
      if (rel == 1) begin
        check({name, ".g_req"}, 512'(g_req), 512'(1));
        check({name, ".g_in"}, g_in, {hh, mm});
      end
      if (valid) begin
        valid_cnt++;
        if (valid_first < 0) begin
          valid_first = rel; key_seen = shared_key; rej_seen = reject;
        end
      end
      if (coin_valid && coin_first < 0) begin coin_first = rel; coin_seen = coin; end
      if (ct_ready && ready_first < 0) ready_first = rel;
      if (j_req) begin
        if (jreq_first < 0) jreq_first = rel;
        if (j_z !== zz) jz_ok = 1'b0;
      end
      if (abort && rel == stop) begin
        rst = 1'b1;
        #1;
        check({name, ".rst_busy"}, 512'(busy), 512'(0));
        check({name, ".rst_ct_ready"}, 512'(ct_ready), 512'(0));
        check({name, ".rst_g_j_req"}, 512'({g_req, j_req}), 512'(0));
        check({name, ".rst_key"}, 512'({reject, shared_key}), 512'(0));
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
          g_valid = (k == 2);
          g_out   = {rr, kk};
          @(negedge clk);
          if (valid) valid_cnt++;
          if (busy || g_req || coin_valid) valid_cnt += 100;
        end
        check({name, ".after_rst_quiet"}, 512'(valid_cnt), 512'(0));
        check({name, ".after_rst_coin"}, 512'(coin), 512'(0));
        idle_inputs();
        return;
      end
      // Drive the cycle.
      start   = (rel == 0);
      m_prime = mm; h_ek = hh; z = zz;
      g_valid = (rel == g_rel);
      g_out   = {rr, kk};
      j_valid = use_j && (rel == jv_rel);
      j_out   = jj;
      idx     = (cnt < CT_WORDS) ? cnt : CT_WORDS - 1;
      ct_valid   = (rel < MAXC) ? (vpat[rel] && rel <= lc) : 1'b0;
      ct_last    = (rel >= g_rel + 2) && (cnt == last_at);
      ct_word    = ct_data[idx];
      ct_re_word = ct_data[idx] ^ ((cnt == bad_idx) ? (WORD_W'(1) << bad_bit) : '0);
      if (rel >= g_rel + 2 && ct_valid) cnt++;
      @(negedge clk);
    end
    idle_inputs();

    check({name, ".valid_cycle"}, 512'(valid_first), 512'(vexp));
    check({name, ".valid_count"}, 512'(valid_cnt), 512'(1));
    check({name, ".coin_cycle"}, 512'(coin_first), 512'(g_rel + 1));
    check({name, ".coin"}, 512'(coin_seen), 512'(rr));
    check({name, ".ready_cycle"}, 512'(ready_first), 512'(g_rel + 2));
    check({name, ".key"}, 512'(key_seen), 512'(key_exp));
    check({name, ".reject"}, 512'(rej_seen), 512'(mis));
    check({name, ".j_req_cycle"}, 512'(jreq_first), use_j ? 512'(lc + 1) : 512'(-1));
    check({name, ".j_z"}, 512'(jz_ok), 512'(1));
    check({name, ".idle_busy"}, 512'(busy), 512'(0));
    check({name, ".zeroized"}, {g_in[255:0], coin}, 512'(0));
    check({name, ".j_z_zero"}, 512'(j_z), 512'(0));
    check({name, ".key_hold"}, {255'(0), reject, shared_key}, {255'(0), mis, key_exp});
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_prime = '0; h_ek = '0; z = '0; g_out = '0; j_out = '0;
    repeat (2) @(negedge clk);
    check("reset.outs", {g_req, coin_valid, ct_ready, j_req, valid, busy, reject}, 512'(0));
    check("reset.key", 512'(shared_key), 512'(0));
    check("reset.coin_gin", {coin, g_in[255:0]}, 512'(0));
    rst = 1'b0;
    @(negedge clk);

    run_txn("match",      1, 3, 0, -1,  0, CT_WORDS - 1, 2, 0);
    run_txn("bit70",      1, 3, 0, 70,  0, CT_WORDS - 1, 3, 0);
    run_txn("early_last", 0, 2, 0, -1,  0, 100,          1, 0);
    run_txn("alternate",  0, 4, 1, -1,  0, CT_WORDS - 1, 0, 0);
    run_txn("no_last",    0, 1, 0, -1,  0, CT_WORDS + 5, 2, 0);
    run_txn("abort",      0, 3, 0, -1,  0, CT_WORDS - 1, 2, 1);
    run_txn("post_abort", 1, 3, 0, -1,  0, CT_WORDS - 1, 2, 0);
    for (int t = 0; t < 6; t++) begin
      int bi, la;
      bi = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, CT_WORDS - 1));
      la = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, CT_WORDS + 4)) : CT_WORDS - 1;
      run_txn($sformatf("rand%0d", t), 0, $urandom_range(1, 8), $urandom_range(0, 2),
              bi, $urandom_range(0, WORD_W - 1), la, $urandom_range(0, 4), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
